// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit path.
package uart_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } uart_tx_state_t;

   localparam int   UART_OVERSAMPLE = 16;
   localparam int   UART_DATA_BITS  = 8;
   localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_xmit_if.sv
// Byte handshake between an on-chip producer and the UART transmitter.
interface uart_xmit_if
   import uart_pkg::*;
#(
   parameter int DATA_BITS = UART_DATA_BITS
);
   logic [DATA_BITS-1:0] tx_byte;
   logic                 tx_valid;
   logic                 tx_ready;
   logic                 tx_busy;

   modport master (output tx_byte, output tx_valid, input tx_ready, input tx_busy);
   modport slave  (input tx_byte, input tx_valid, output tx_ready, output tx_busy);
endinterface

// File: rtl/uart_bit_timer.sv
// Oversample tick counter: held at zero while clr_i, otherwise free-running with a wrap pulse.
module uart_bit_timer #(
   parameter int OVERSAMPLE = 16
) (
   input  logic uart_sampling_clk,
   input  logic rst,
   input  logic clr_i,
   output logic wrap_o
);
   localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;

   logic [TW-1:0] tick_q;

   always_ff @(posedge uart_sampling_clk or posedge rst) begin
      if (rst) begin
         tick_q <= '0;
      end else if (clr_i) begin
         tick_q <= '0;
      end else begin
         tick_q <= tick_q + TW'(1);
      end
   end

   // Power-of-two OVERSAMPLE lets the counter wrap on its own after the last tick.
   assign wrap_o = !clr_i && (tick_q == TW'(OVERSAMPLE - 1));
endmodule

// File: rtl/uart_xmit.sv
// UART transmitter with one-entry holding register; start, MSB-first data, stop bits.
// Define UART_TX_RTS_EN to gate frame starts on a synchronised USB_RTS (0 = PC ready).
module uart_xmit
   import uart_pkg::*;
#(
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int DATA_BITS  = UART_DATA_BITS,
   parameter int STOP_BITS  = 1
) (
   input  logic        uart_sampling_clk,
   input  logic        rst,
   uart_xmit_if.slave  tx_if,
   input  logic        USB_RTS,
   output logic        USB_TX
);
   localparam int BCW = $clog2(DATA_BITS + 1);

   uart_tx_state_t       state_q, state_d;
   logic [DATA_BITS-1:0] hold_q, hold_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 hold_full_q, hold_full_d;
   logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
   logic                 tx_q, tx_d;
   logic                 busy_q;
   logic                 wrap;
   logic                 can_start;
   logic                 accept;

`ifdef UART_TX_RTS_EN
   logic [1:0] rts_sync_q;

   // Powers up as "PC not ready" so nothing leaves before RTS has been seen low.
   always_ff @(posedge uart_sampling_clk or posedge rst) begin
      if (rst) begin
         rts_sync_q <= 2'b11;
      end else begin
         rts_sync_q <= {rts_sync_q[0], USB_RTS};
      end
   end

   assign can_start = hold_full_q && !rts_sync_q[1];
`else
   logic unused_rts;
   assign unused_rts = USB_RTS;
   assign can_start  = hold_full_q;
`endif

   assign accept         = tx_if.tx_valid && !hold_full_q;
   assign tx_if.tx_ready = !hold_full_q;
   assign tx_if.tx_busy  = busy_q;
   assign USB_TX         = tx_q;

   uart_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
      .uart_sampling_clk (uart_sampling_clk),
      .rst               (rst),
      .clr_i             (state_q == S_IDLE),
      .wrap_o            (wrap)
   );

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      bit_cnt_d   = bit_cnt_q;
      tx_d        = tx_q;

      // Accept only happens with hold empty, load only with hold full: never both.
      if (accept) begin
         hold_d      = tx_if.tx_byte;
         hold_full_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (can_start) begin
               shift_d     = hold_q;
               hold_full_d = 1'b0;
               tx_d        = 1'b0;
               state_d     = S_START;
            end
         end
         S_START: begin
            if (wrap) begin
               tx_d      = shift_q[DATA_BITS-1];
               bit_cnt_d = '0;
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (wrap) begin
               if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
                  tx_d      = UART_IDLE_LEVEL;
                  bit_cnt_d = '0;
                  state_d   = S_STOP;
               end else begin
                  shift_d   = shift_q << 1;
                  tx_d      = shift_d[DATA_BITS-1];
                  bit_cnt_d = bit_cnt_q + BCW'(1);
               end
            end
         end
         S_STOP: begin
            if (wrap) begin
               if (bit_cnt_q == BCW'(STOP_BITS - 1)) begin
                  if (can_start) begin
                     shift_d     = hold_q;
                     hold_full_d = 1'b0;
                     tx_d        = 1'b0;
                     state_d     = S_START;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + BCW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge uart_sampling_clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         bit_cnt_q   <= '0;
         tx_q        <= UART_IDLE_LEVEL;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         tx_q        <= tx_d;
         busy_q      <= (state_d != S_IDLE);
      end
   end
endmodule

// File: tb/tb_uart_xmit.sv
// Self-checking bench for uart_xmit: expected line levels come from the frame rule per cycle.
`timescale 1ns/1ps
module tb_uart_xmit;
   localparam int OS    = 16;
   localparam int FRAME = (8 + 1 + 1) * OS;

   logic clk = 1'b0;
   logic rst;
   logic usb_rts;
   logic usb_tx;
   int   checks   = 0;
   int   failures = 0;
   int   rx_count = 0;

   uart_xmit_if #(.DATA_BITS(8)) bus ();

   uart_xmit #(.OVERSAMPLE(OS), .DATA_BITS(8), .STOP_BITS(1)) dut (
      .uart_sampling_clk (clk),
      .rst               (rst),
      .tx_if             (bus.slave),
      .USB_RTS           (usb_rts),
      .USB_TX            (usb_tx)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Line level k cycles into a frame: start 0, data MSB first, stop 1.
   function automatic logic exp_line(input logic [7:0] b, input int k);
      int slot;
      slot = k / OS;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return b[8 - slot];
      return 1'b1;
   endfunction

   // Returns just after the accepting edge E0.
   task automatic send(input logic [7:0] b, input string tag);
      bit done;
      done = 1'b0;
      bus.tx_byte  = b;
      bus.tx_valid = 1'b1;
      for (int i = 0; i < 4 * FRAME && !done; i++) begin
         done = bus.tx_ready;
         tick();
      end
      bus.tx_valid = 1'b0;
      bus.tx_byte  = 8'($urandom);
      if (!done) chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
   endtask

   // Entered just after E1; checks every cycle and decodes mid-bit like a 16x receiver.
   task automatic check_frame(input logic [7:0] b, input string tag, output logic [7:0] rx);
      logic stop_ok;
      rx      = '0;
      stop_ok = 1'b0;
      for (int k = 0; k < FRAME; k++) begin
         chk($sformatf("%s_line_c%0d", tag, k), {31'd0, usb_tx}, {31'd0, exp_line(b, k)});
         if (k % OS == 0) chk($sformatf("%s_busy_c%0d", tag, k), {31'd0, bus.tx_busy}, 32'd1);
         if (k % OS == OS / 2 && k / OS >= 1 && k / OS <= 8) rx = {rx[6:0], usb_tx};
         if (k == 9 * OS + OS / 2) stop_ok = usb_tx;
         tick();
      end
      if (stop_ok) rx_count++;
      chk({tag, "_idle_after"}, {31'd0, usb_tx}, 32'd1);
      chk({tag, "_busy_after"}, {31'd0, bus.tx_busy}, 32'd0);
      chk({tag, "_rx_byte"}, {24'd0, rx}, {24'd0, b});
   endtask

   // Second byte offered right after the first is loaded; it must follow with zero gap.
   task automatic two_frames(input logic [7:0] b1, input logic [7:0] b2, input string tag);
      logic exp;
      send(b1, tag);
      tick();
      bus.tx_byte  = b2;
      bus.tx_valid = 1'b1;
      for (int k = 0; k < 2 * FRAME; k++) begin
         exp = (k < FRAME) ? exp_line(b1, k) : exp_line(b2, k - FRAME);
         chk($sformatf("%s_line_c%0d", tag, k), {31'd0, usb_tx}, {31'd0, exp});
         if (k == 0) chk({tag, "_ready_c0"}, {31'd0, bus.tx_ready}, 32'd1);
         if (k == 1) begin
            bus.tx_valid = 1'b0;
            bus.tx_byte  = 8'($urandom);
         end
         // Offer while full: must be ignored.
         if (k == 40) begin
            bus.tx_byte  = ~b2;
            bus.tx_valid = 1'b1;
         end
         if (k == 50) bus.tx_valid = 1'b0;
         if (k >= 1 && k < FRAME && k % OS == 1)
            chk($sformatf("%s_ready_c%0d", tag, k), {31'd0, bus.tx_ready}, 32'd0);
         if (k == FRAME) chk({tag, "_ready_drained"}, {31'd0, bus.tx_ready}, 32'd1);
         if (k % OS == 0) chk($sformatf("%s_busy_c%0d", tag, k), {31'd0, bus.tx_busy}, 32'd1);
         tick();
      end
      for (int i = 0; i < 20; i++) begin
         chk({tag, "_no_third"}, {31'd0, usb_tx}, 32'd1);
         tick();
      end
      chk({tag, "_busy_end"}, {31'd0, bus.tx_busy}, 32'd0);
   endtask

   initial begin
      logic [7:0] rx;
      logic [7:0] lb [6];
      int         rx_base;

      rst          = 1'b1;
      usb_rts      = 1'b0;
      bus.tx_valid = 1'b0;
      bus.tx_byte  = 8'h00;
      repeat (3) tick();
      chk("reset_tx", {31'd0, usb_tx}, 32'd1);
      chk("reset_ready", {31'd0, bus.tx_ready}, 32'd1);
      chk("reset_busy", {31'd0, bus.tx_busy}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 50; i++) begin
         if (i % 10 == 0) begin
            chk("idle_tx", {31'd0, usb_tx}, 32'd1);
            chk("idle_ready", {31'd0, bus.tx_ready}, 32'd1);
            chk("idle_busy", {31'd0, bus.tx_busy}, 32'd0);
         end
         tick();
      end

      send(8'hA5, "a5");
      chk("a5_line_at_e0", {31'd0, usb_tx}, 32'd1);
      chk("a5_ready_at_e0", {31'd0, bus.tx_ready}, 32'd0);
      tick();
      check_frame(8'hA5, "a5", rx);

      two_frames(8'h3C, 8'hC3, "b2b");
      two_frames(8'($urandom), 8'($urandom), "b2b_rand");

      // Reset during data bit 4 of 8'h6A (a 0 bit), with a second byte parked in hold.
      send(8'h6A, "rst");
      tick();
      for (int k = 0; k < 70; k++) begin
         chk($sformatf("rst_line_c%0d", k), {31'd0, usb_tx}, {31'd0, exp_line(8'h6A, k)});
         if (k == 2) begin
            bus.tx_byte  = 8'h99;
            bus.tx_valid = 1'b1;
         end
         if (k == 3) bus.tx_valid = 1'b0;
         tick();
      end
      chk("rst_pre_line", {31'd0, usb_tx}, 32'd0);
      chk("rst_pre_ready", {31'd0, bus.tx_ready}, 32'd0);
      rst = 1'b1;
      #1;
      chk("rst_mid_tx", {31'd0, usb_tx}, 32'd1);
      chk("rst_mid_busy", {31'd0, bus.tx_busy}, 32'd0);
      chk("rst_mid_ready", {31'd0, bus.tx_ready}, 32'd1);
      repeat (2) tick();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         chk("rst_discard_tx", {31'd0, usb_tx}, 32'd1);
         chk("rst_discard_busy", {31'd0, bus.tx_busy}, 32'd0);
         tick();
      end
      send(8'h00, "post_rst");
      tick();
      check_frame(8'h00, "post_rst", rx);

`ifdef UART_TX_RTS_EN
      usb_rts = 1'b1;
      repeat (3) tick();
      send(8'h81, "rts");
      for (int i = 0; i < 30; i++) begin
         chk("rts_hold_tx", {31'd0, usb_tx}, 32'd1);
         chk("rts_hold_ready", {31'd0, bus.tx_ready}, 32'd0);
         chk("rts_hold_busy", {31'd0, bus.tx_busy}, 32'd0);
         tick();
      end
      usb_rts = 1'b0;
      tick();
      chk("rts_sync1_tx", {31'd0, usb_tx}, 32'd1);
      tick();
      chk("rts_sync2_tx", {31'd0, usb_tx}, 32'd1);
      tick();
      check_frame(8'h81, "rts", rx);
`endif

      // Loopback decode of directed and random bytes.
      lb[0] = 8'h00;
      lb[1] = 8'hFF;
      lb[2] = 8'h55;
      for (int i = 3; i < 6; i++) lb[i] = 8'($urandom);
      rx_base = rx_count;
      for (int i = 0; i < 6; i++) begin
         send(lb[i], $sformatf("lb%0d", i));
         tick();
         check_frame(lb[i], $sformatf("lb%0d", i), rx);
         chk($sformatf("lb%0d_byte_count", i), rx_count - rx_base, i + 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
